// File: rtl/icache_response_router_if.sv
// Handshake bundle between the request side, the instruction cache and the
// response router: tag capture inputs, cache return inputs and broadcast outputs.
interface icache_response_router_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [4:0]    selectLine;
    logic          reqIssue;
    logic          reqReady;
    logic          cacheValid;
    logic [31:0]   cacheData;
    logic [31:0]   respData;
    logic [31:0]   respValid;
    logic [CW-1:0] outstanding;
    logic          respError;

    modport master (
        output selectLine, reqIssue, cacheValid, cacheData,
        input  reqReady, respData, respValid, outstanding, respError
    );

    modport slave (
        input  selectLine, reqIssue, cacheValid, cacheData,
        output reqReady, respData, respValid, outstanding, respError
    );
endinterface

// File: rtl/icache_response_router.sv
// In-order tag FIFO routing icache return words to the owning thread processor.
// Optional ICACHE_RESP_ERR_EN enables the sticky spurious-response flag.
module icache_response_router #(
    parameter int DEPTH = 4
) (
    input logic                     clk,
    input logic                     reset,
    icache_response_router_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [4:0]    tags [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [31:0]   resp_valid_q;
    logic [31:0]   resp_data_q;

    // A return with nothing held is dropped; no bypass from a same-cycle push.
    assign push = bus.reqIssue && (state != FULL);
    assign pop  = bus.cacheValid && (state != EMPTY);

    always_comb begin
        state_n = state;
        unique case (state)
            EMPTY: begin
                if (push) state_n = PARTIAL;
            end
            PARTIAL: begin
                if (push && !pop && count == CW'(DEPTH - 1))
                    state_n = FULL;
                else if (pop && !push && count == CW'(1))
                    state_n = EMPTY;
            end
            FULL: begin
                if (pop) state_n = PARTIAL;
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_n;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) tags[wr_ptr] <= bus.selectLine;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else if (pop) begin
            resp_valid_q <= 32'd1 << tags[rd_ptr];
            resp_data_q  <= bus.cacheData;
        end else begin
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end
    end

    assign bus.respValid   = resp_valid_q;
    assign bus.respData    = resp_data_q;
    assign bus.reqReady    = (state != FULL);
    assign bus.outstanding = count;

`ifdef ICACHE_RESP_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else if (bus.cacheValid && state == EMPTY)
            err_q <= 1'b1;
    end

    assign bus.respError = err_q;
`else
    assign bus.respError = 1'b0;
`endif
endmodule

// File: doc/icache_response_router.md
# icache_response_router

Return-path router between the shared 4 KB instruction cache and the 32 thread processors. Records the processor ID of every address the cache accepts in an in-order tag FIFO. When the cache returns data, it pops the oldest tag and broadcasts the data on a shared response bus, with a one-hot valid strobe to the owning processor. It is the response-side counterpart of the request address multiplexer.

## Interface
- DEPTH, 4, tag FIFO entries (maximum outstanding cache requests); power of two, 2..16.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- selectLine  input  5  processor ID of the request currently driven to the cache.
- reqIssue  input  1  cache accepted the request tagged by selectLine this cycle.
- reqReady  output  1  tag FIFO can accept a push; `!full`, combinational from state.
- cacheValid  input  1  cache returns one data word this cycle.
- cacheData  input  32  instruction word from the cache.
- respData  output  32  registered broadcast data; all zeros when no respValid bit is set (wired-OR safe).
- respValid  output  32  registered one-hot strobe; bit n means respData belongs to processor n.
- outstanding  output  $clog2(DEPTH)+1  number of tags held.
- respError  output  1  sticky spurious-response flag; see Configuration.

## Operation
- Tag FIFO: DEPTH×5-bit storage, write pointer, read pointer, count. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Push: `reqIssue && reqReady` writes selectLine at the write pointer, then increments the write pointer.
  - A reqIssue while full is ignored: no push, and count does not change. The cache must not accept requests while reqReady=0.
- Pop: `cacheValid && count!=0` reads the tag at the read pointer and increments the read pointer.
  - Next cycle: respValid = 1<<tag and respData = cacheData.
- Push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - This is legal when full: reqReady is 0, so there is no push, and the pop frees an entry on the next cycle.
- No same-cycle bypass. A cacheValid while count==0 is spurious, even if a push happens in that cycle.
  - A spurious response is dropped.
  - respValid and respData stay 0 on the next cycle.
- States: EMPTY (count 0), PARTIAL, FULL (count DEPTH), derived from count. Transitions are only ±1 per cycle, or 0 on simultaneous push/pop.
- Reset, including mid-operation:
  - Count, pointers, respValid, respData and respError all go to 0.
  - Pending tags are discarded.
  - reqReady=1 and outstanding=0 while reset is asserted.

## Timing
- Response latency: one cycle from cacheValid (at edge N) to respValid/respData (after edge N).
- respValid is a one-cycle pulse per response. Back-to-back cacheValid gives back-to-back pulses, possibly to different processors.
- reqReady and outstanding reflect the registered count. They update on the cycle after a push or pop.
- Ordering: responses are delivered strictly in issue order. The cache is in-order.

## Configuration
- Macro: ICACHE_RESP_ERR_EN.
- Defined: a spurious cacheValid (count==0) sets respError on the next edge. respError stays 1 until reset.
- Undefined: no detection logic, respError is tied 0, and spurious responses are still silently dropped.

## Test plan
- Reset, then issue ID 7 and then ID 31 on consecutive cycles. Return words 0xDEAD0007 and 0xBEEF001F on the next two cycles.
  - Expect respValid=0x00000080 with respData=0xDEAD0007, then respValid=0x80000000 with respData=0xBEEF001F.
  - outstanding goes 1,2,1,0.
- Fill with DEPTH=4 (IDs 0,1,2,3) and drive a 5th reqIssue with ID 9.
  - Expect reqReady=0 and outstanding=4.
  - The 5th tag is not stored: four returns strobe bits 0,1,2,3 only.
- Full FIFO, cacheValid and reqIssue in the same cycle.
  - Expect the pop to strobe the oldest ID and outstanding=3.
  - reqReady=1 on the next cycle, and a following issue is accepted.
- Empty FIFO, cacheValid with data 0x12345678.
  - Expect respValid=0 and respData=0.
  - With ICACHE_RESP_ERR_EN, respError=1 and it holds across later traffic.
  - Without the macro, respError=0.
- Issue 10 requests with continuous interleaved returns, pointer wrap ≥2 times, random IDs.
  - Scoreboard: each response is one-hot to the matching ID, in order.
- Assert reset with 3 outstanding.
  - Expect all outputs 0 and reqReady=1 immediately.
  - Post-reset cacheValid is spurious.
